maxmin_feeder: RTL

Stream source and result collector for the `maxmin` block. It holds a DEPTH-entry signed sample buffer, or generates an alternating-sign ramp internally. On `start` it drives one sample per clock into the consumer's data input, then waits for the consumer's `rdy` and captures its 16-bit result. It sits between a host/testbench-side register interface and the `maxmin` datapath, so a complete min/max run can be launched and read back with one command.

---
 rtl/maxmin_pkg.sv | 25 ++
 rtl/feeder_buf.sv | 32 +++
 rtl/maxmin_feeder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/maxmin_pkg.sv
// Shared constants for the maxmin feeder: default geometry, FSM encoding and
// the alternating-sign ramp used as the built-in test pattern.
package maxmin_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_TIMEOUT = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // g(k) = k+1 for even k, -(k+1) for odd k; callers truncate to their width
  function automatic logic [31:0] ramp_val(input logic [31:0] k);
    logic [31:0] mag;
    mag = k + 32'd1;
    if (k[0]) begin
      ramp_val = (~mag) + 32'd1;
    end else begin
      ramp_val = mag;
    end
  endfunction

endpackage

// File: rtl/feeder_buf.sv
// DEPTH x WIDTH sample store: async-clear, one synchronous write port and one
// combinational read port.
module feeder_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // storage array, cleared by reset
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxmin_feeder.sv
// Stream source and result collector for the maxmin block: sends DEPTH samples
// (buffer or ramp), waits for the consumer's rdy and captures its result.
module maxmin_feeder
  import maxmin_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     mode,
  input  logic                     start,
  output logic [WIDTH-1:0]         din,
  output logic                     din_vld,
  input  logic                     rdy,
  input  logic [WIDTH-1:0]         dout,
  output logic [WIDTH-1:0]         result,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] cap_q, cap_d;

  logic [WIDTH-1:0] din_q;
  logic             din_vld_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;

  logic             buf_we_s;
  logic [WIDTH-1:0] buf_rdata_s;
  logic [WIDTH-1:0] ramp_s;
  logic [WIDTH-1:0] sample_s;

  // the buffer is frozen while a run is in flight
  assign buf_we_s = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  feeder_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_ni  (rst),
    .we_i    (buf_we_s),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (idx_q),
    .rdata_o (buf_rdata_s)
  );

  assign ramp_s   = WIDTH'(ramp_val(32'(idx_q)));
  assign sample_s = mode_q ? ramp_s : buf_rdata_s;

  // next-state logic for the run sequencer, index and timeout counters
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          mode_d  = mode;
          err_d   = 1'b0;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == IDX_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        // rdy takes priority over a timeout expiring in the same cycle
        if (rdy) begin
          cap_d   = dout;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // sequencer state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
    end
  end

  // registered outputs, decoded from the current state one cycle behind it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q     <= '0;
      din_vld_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      din_q     <= (state_q == ST_SEND) ? sample_s : '0;
      din_vld_q <= (state_q == ST_SEND);
      busy_q    <= (state_q == ST_SEND) || (state_q == ST_WAIT);
      done_q    <= (state_q == ST_DONE);
      result_q  <= (state_q == ST_DONE) ? cap_q : result_q;
    end
  end

  assign din     = din_q;
  assign din_vld = din_vld_q;
  assign result  = result_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
